// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential fetch from a 1-cycle-latency RAM into a 2-entry prefetch FIFO.
// Optional IFU_PERF_COUNT_EN adds oBubbleCount, a saturating count of cycles without a valid entry.
module instruction_fetch_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oMemAddress,
    input  logic [DATA_WIDTH-1:0] iMemData,
    input  logic                  iBranchTaken,
    input  logic [ADDR_WIDTH-1:0] iBranchTarget,
    output logic                  oInstrValid,
    input  logic                  iInstrReady,
    output logic [DATA_WIDTH-1:0] oInstr,
`ifdef IFU_PERF_COUNT_EN
    output logic [15:0]           oBubbleCount,
`endif
    output logic [ADDR_WIDTH-1:0] oInstrPC
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic                  pending;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] s_instr [2];
    logic [ADDR_WIDTH-1:0] s_pc    [2];

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            in_flight;
    logic [1:0]            cnt_after_pop;
    logic [1:0]            n_count;
    logic [ADDR_WIDTH-1:0] n_pc;
    logic [DATA_WIDTH-1:0] n_instr [2];
    logic [ADDR_WIDTH-1:0] n_spc   [2];

    assign oMemAddress = pc;
    assign oInstrValid = (count != 2'd0) & ~iBranchTaken;
    assign oInstr      = s_instr[0];
    assign oInstrPC    = s_pc[0];

    assign pop  = oInstrValid & iInstrReady;
    assign push = pending;

    // Occupancy counts the in-flight read so the FIFO can never overflow.
    assign in_flight = {1'b0, count} + {2'b00, pending};
    assign issue     = ~iBranchTaken & (in_flight < (3'd2 + {2'b00, pop}));

    always_comb begin
        n_pc = pc;
        if (iBranchTaken)
            n_pc = iBranchTarget;
        else if (issue)
            n_pc = pc + 1'b1;
    end

    always_comb begin
        n_instr       = s_instr;
        n_spc         = s_pc;
        cnt_after_pop = count - {1'b0, pop};
        if (pop) begin
            n_instr[0] = s_instr[1];
            n_spc[0]   = s_pc[1];
        end
        if (push) begin
            n_instr[cnt_after_pop[0]] = iMemData;
            n_spc[cnt_after_pop[0]]   = pend_pc;
        end
        n_count = cnt_after_pop + {1'b0, push};
        if (iBranchTaken)
            n_count = 2'd0;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc         <= RESET_ADDR;
            pend_pc    <= '0;
            pending    <= 1'b0;
            count      <= 2'd0;
            s_instr[0] <= '0;
            s_instr[1] <= '0;
            s_pc[0]    <= '0;
            s_pc[1]    <= '0;
        end else begin
            pc      <= n_pc;
            pending <= issue;
            if (issue)
                pend_pc <= pc;
            count   <= n_count;
            s_instr <= n_instr;
            s_pc    <= n_spc;
        end
    end

`ifdef IFU_PERF_COUNT_EN
    logic [15:0] bubbles;

    assign oBubbleCount = bubbles;

    always_ff @(posedge Clock) begin
        if (!Reset)
            bubbles <= 16'd0;
        else if (!oInstrValid && (bubbles != 16'hFFFF))
            bubbles <= bubbles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch unit.
// Expected {instr,pc} pairs are queued from a RAM model and compared at every valid cycle.
module tb_instruction_fetch_unit;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [AW-1:0] oMemAddress;
    logic [DW-1:0] iMemData;
    logic          iBranchTaken = 1'b0;
    logic [AW-1:0] iBranchTarget = '0;
    logic          oInstrValid;
    logic          iInstrReady = 1'b0;
    logic [DW-1:0] oInstr;
    logic [AW-1:0] oInstrPC;
`ifdef IFU_PERF_COUNT_EN
    logic [15:0]   oBubbleCount;
`endif

    instruction_fetch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_ADDR('0)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oMemAddress  (oMemAddress),
        .iMemData     (iMemData),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oInstrValid  (oInstrValid),
        .iInstrReady  (iInstrReady),
        .oInstr       (oInstr),
`ifdef IFU_PERF_COUNT_EN
        .oBubbleCount (oBubbleCount),
`endif
        .oInstrPC     (oInstrPC)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always @(posedge Clock) iMemData <= ram[oMemAddress];

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } pair_t;

    pair_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    xfers  = 0;
    bit    hold   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [AW-1:0] start, input int n);
        for (int k = 0; k < n; k++) begin
            automatic logic [AW-1:0] a = AW'(int'(start) + k);
            exp_q.push_back({ram[a], a});
        end
    endtask

    // One cycle: drive inputs after the falling edge, then score the head.
    task automatic tick(input bit rst, input bit rdy, input bit br, input logic [AW-1:0] tgt);
        @(negedge Clock);
        Reset         = rst;
        iInstrReady   = rdy;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        #1;
        if (br)
            check("br_gate", {31'd0, oInstrValid}, 32'd0);
        if (hold && !br)
            check("hold_valid", {31'd0, oInstrValid}, 32'd1);
        if (oInstrValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 32'd1);
            end else begin
                check("instr", {16'd0, oInstr}, {16'd0, exp_q[0].instr});
                check("pc", {22'd0, oInstrPC}, {22'd0, exp_q[0].pc});
                if (rdy) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
        end
        hold = (oInstrValid === 1'b1) && !rdy && rst;
    endtask

    task automatic do_reset(input bit rdy);
        tick(1'b0, rdy, 1'b0, '0);
        exp_q.delete();
        push_seq('0, 1500);
    endtask

    always @(posedge Clock) begin
        if (Reset && !iBranchTaken && dut.pending && (dut.count == 2'd2)
            && !(oInstrValid && iInstrReady)) begin
            errors++;
            $display("FAIL push_full: push into full FIFO at %0t", $time);
        end
    end

    int x0;
    bit rb;
    logic [AW-1:0] rt;

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            ram[i] = DW'((i * 40503) ^ 16'hA5C3);

        // Reset and first fetches
        do_reset(1'b0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("c1_valid", {31'd0, oInstrValid}, 32'd0);
        check("c1_addr", {22'd0, oMemAddress}, 32'd0);
        check("c1_instr", {16'd0, oInstr}, 32'd0);
        check("c1_pc", {22'd0, oInstrPC}, 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("c2_valid", {31'd0, oInstrValid}, 32'd0);
        check("c2_addr", {22'd0, oMemAddress}, 32'd1);
        x0 = xfers;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, '0);
            check("stream_valid", {31'd0, oInstrValid}, 32'd1);
        end
        check("stream_xfers", xfers - x0, 32'd4);

        // Back-pressure
        do_reset(1'b1);
        tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            check("stall_instr", {16'd0, oInstr}, {16'd0, ram[0]});
            check("stall_addr", {22'd0, oMemAddress}, 32'd2);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0, '0);
            check("resume_valid", {31'd0, oInstrValid}, 32'd1);
        end

        // Branch to the top address wraps to 0
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 10'h3FF);
        exp_q.delete();
        push_seq(10'h3FF, 1500);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b0, '0);
            check("br_bubble", {31'd0, oInstrValid}, 32'd0);
        end
        tick(1'b1, 1'b1, 1'b0, '0);
        check("br3_valid", {31'd0, oInstrValid}, 32'd1);
        check("br3_pc", {22'd0, oInstrPC}, 32'h3FF);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("br4_pc", {22'd0, oInstrPC}, 32'd0);

        // Back-to-back branches
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 10'h010);
        tick(1'b1, 1'b1, 1'b1, 10'h020);
        exp_q.delete();
        push_seq(10'h020, 1500);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b0, '0);
            check("bb_bubble", {31'd0, oInstrValid}, 32'd0);
        end
        tick(1'b1, 1'b1, 1'b0, '0);
        check("bb_valid", {31'd0, oInstrValid}, 32'd1);
        check("bb_pc", {22'd0, oInstrPC}, 32'h20);

        // Reset while full
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, '0);
        check("full_addr", {22'd0, oMemAddress}, 32'd2);
        do_reset(1'b1);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("rst_valid", {31'd0, oInstrValid}, 32'd0);
        check("rst_addr", {22'd0, oMemAddress}, 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("rst_c3_valid", {31'd0, oInstrValid}, 32'd1);
        check("rst_c3_pc", {22'd0, oInstrPC}, 32'd0);

`ifdef IFU_PERF_COUNT_EN
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, '0);
        check("bubbles", {16'd0, oBubbleCount}, 32'd2);
`endif

        // Random ready and branches
        do_reset(1'b1);
        x0 = xfers;
        for (int i = 0; i < 600; i++) begin
            rb = ($urandom_range(0, 19) == 0);
            rt = AW'($urandom_range(0, (1 << AW) - 1));
            tick(1'b1, ($urandom_range(0, 3) != 0), rb, rt);
            if (rb) begin
                exp_q.delete();
                push_seq(rt, 1500);
            end
        end
        check("rand_progress", {31'd0, (xfers - x0) > 200}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
